cache_refill: RTL

CACHE_REFILL -- requirements
Module: cache_refill

---
 rtl/cache_refill_pkg.sv | 25 ++
 rtl/cache_refill_line_buffer.sv | 30 +++
 rtl/cache_refill.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cache_refill_pkg.sv
// Shared cache parameters, refill FSM state encoding and beat-count helper.
package cache_refill_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WB   = 2'd1,
      ST_RD   = 2'd2,
      ST_FILL = 2'd3
   } refill_state_t;

   localparam int ADDR_WIDTH          = 32;
   localparam int DEF_LINE_SIZE_BYTES = 64;
   localparam int DEF_DATA_WIDTH      = 32;
   localparam int DEF_INDEX_BITS      = 8;
   localparam int OFFSET_BITS         = $clog2(DEF_LINE_SIZE_BYTES);
   localparam int DEF_TAG_BITS        = ADDR_WIDTH - DEF_INDEX_BITS - OFFSET_BITS;

   // Number of memory beats needed to move one full line.
   function automatic int beats_per_line(input int line_bytes, input int data_width);
      return (line_bytes * 8) / data_width;
   endfunction

   localparam int BEATS_PER_LINE = beats_per_line(DEF_LINE_SIZE_BYTES, DEF_DATA_WIDTH);

endpackage

// File: rtl/cache_refill_line_buffer.sv
// Line assembly buffer: one memory beat written per enabled cycle.
module refill_line_buffer
   import cache_refill_pkg::*;
#(
   parameter int LINE_W     = DEF_LINE_SIZE_BYTES * 8,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BEAT_W     = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [BEAT_W-1:0]     wr_beat,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [LINE_W-1:0]     line
);

   logic [LINE_W-1:0] line_r;

   // Store the incoming beat into its slot, beat 0 at the least significant end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_r <= {LINE_W{1'b0}};
      end else if (wr_en) begin
         line_r[wr_beat*DATA_WIDTH +: DATA_WIDTH] <= wr_data;
      end
   end

   assign line = line_r;

endmodule

// File: rtl/cache_refill.sv
// Cache miss handler: optional victim writeback, line read, one-cycle fill strobe.
module cache_refill
   import cache_refill_pkg::*;
#(
   parameter int LINE_SIZE_BYTES = DEF_LINE_SIZE_BYTES,
   parameter int TAG_BITS        = DEF_TAG_BITS,
   parameter int INDEX_BITS      = DEF_INDEX_BITS,
   parameter int DATA_WIDTH      = DEF_DATA_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_miss_valid,
   output logic                         o_miss_ready,
   input  logic [TAG_BITS-1:0]          i_tag,
   input  logic [INDEX_BITS-1:0]        i_index,
   input  logic                         i_victim_dirty,
   input  logic [TAG_BITS-1:0]          i_victim_tag,
   input  logic [LINE_SIZE_BYTES*8-1:0] i_victim_data,
   output logic                         o_mem_req,
   output logic                         o_mem_we,
   output logic [ADDR_WIDTH-1:0]        o_mem_addr,
   output logic [DATA_WIDTH-1:0]        o_mem_wdata,
   input  logic                         i_mem_ack,
   input  logic [DATA_WIDTH-1:0]        i_mem_rdata,
   output logic                         o_fill_valid,
   output logic [TAG_BITS-1:0]          o_fill_tag,
   output logic [INDEX_BITS-1:0]        o_fill_index,
   output logic [LINE_SIZE_BYTES*8-1:0] o_fill_data,
   output logic                         o_busy
);

   localparam int LINE_W     = LINE_SIZE_BYTES * 8;
   localparam int BEATS      = beats_per_line(LINE_SIZE_BYTES, DATA_WIDTH);
   localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFF_W      = $clog2(LINE_SIZE_BYTES);
   localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   refill_state_t           state_r, state_s;
   logic [BEAT_W-1:0]       beat_r, beat_s;
   logic [TAG_BITS-1:0]     tag_r, tag_s, vtag_r, vtag_s;
   logic [INDEX_BITS-1:0]   index_r, index_s;
   logic [LINE_W-1:0]       vdata_r, vdata_s;
   logic                    accept_s, ack_s, last_s, buf_we_s;
   logic [LINE_W-1:0]       line_s, fill_line_s;
   logic [OFF_W-1:0]        offset_s;

   logic                    mem_req_r, mem_req_s, mem_we_r, mem_we_s;
   logic [ADDR_WIDTH-1:0]   mem_addr_r, mem_addr_s;
   logic [DATA_WIDTH-1:0]   mem_wdata_r, mem_wdata_s;
   logic                    fill_valid_r, fill_valid_s;
   logic [TAG_BITS-1:0]     fill_tag_r, fill_tag_s;
   logic [INDEX_BITS-1:0]   fill_index_r, fill_index_s;
   logic [LINE_W-1:0]       fill_data_r, fill_data_s;
   logic                    busy_r, busy_s, miss_ready_r, miss_ready_s;

   // An ack only counts while a beat is actually being requested.
   assign accept_s = i_miss_valid & (state_r == ST_IDLE);
   assign ack_s    = i_mem_ack & mem_req_r;
   assign last_s   = (beat_r == LAST_BEAT);
   assign buf_we_s = ack_s & (state_r == ST_RD);

   refill_line_buffer #(
      .LINE_W     (LINE_W),
      .DATA_WIDTH (DATA_WIDTH),
      .BEAT_W     (BEAT_W)
   ) u_line_buffer (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (buf_we_s),
      .wr_beat (beat_r),
      .wr_data (i_mem_rdata),
      .line    (line_s)
   );

   // Next state, beat counter and captured miss context.
   always_comb begin
      state_s = state_r;
      beat_s  = beat_r;
      tag_s   = tag_r;
      index_s = index_r;
      vtag_s  = vtag_r;
      vdata_s = vdata_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_s = i_victim_dirty ? ST_WB : ST_RD;
               beat_s  = {BEAT_W{1'b0}};
               tag_s   = i_tag;
               index_s = i_index;
               vtag_s  = i_victim_tag;
               vdata_s = i_victim_data;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WB, ST_RD: begin
            if (ack_s && last_s) begin
               state_s = (state_r == ST_WB) ? ST_RD : ST_FILL;
               beat_s  = {BEAT_W{1'b0}};
            end else if (ack_s) begin
               beat_s = beat_r + BEAT_W'(1);
            end else begin
               beat_s = beat_r;
            end
         end
         ST_FILL: begin
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
            beat_s  = {BEAT_W{1'b0}};
         end
      endcase
   end

   // Output values for the coming cycle; address and wdata hold when no beat is requested.
   always_comb begin
      mem_req_s    = (state_s == ST_WB) || (state_s == ST_RD);
      mem_we_s     = (state_s == ST_WB);
      busy_s       = (state_s != ST_IDLE);
      miss_ready_s = (state_s == ST_IDLE);
      fill_valid_s = (state_s == ST_FILL);
      offset_s     = OFF_W'(beat_s) << BYTE_SHIFT;
      mem_addr_s   = mem_addr_r;
      mem_wdata_s  = mem_wdata_r;
      fill_line_s  = line_s;
      fill_line_s[beat_r*DATA_WIDTH +: DATA_WIDTH] = i_mem_rdata;
      if (mem_req_s) begin
         mem_addr_s = ADDR_WIDTH'({((state_s == ST_WB) ? vtag_s : tag_s), index_s, offset_s});
         if (state_s == ST_WB) begin
            mem_wdata_s = vdata_s[beat_s*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            mem_wdata_s = mem_wdata_r;
         end
      end else begin
         mem_addr_s  = mem_addr_r;
         mem_wdata_s = mem_wdata_r;
      end
      if (fill_valid_s) begin
         fill_tag_s   = tag_s;
         fill_index_s = index_s;
         fill_data_s  = fill_line_s;
      end else begin
         fill_tag_s   = fill_tag_r;
         fill_index_s = fill_index_r;
         fill_data_s  = fill_data_r;
      end
   end

   // State, context and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         beat_r       <= {BEAT_W{1'b0}};
         tag_r        <= {TAG_BITS{1'b0}};
         index_r      <= {INDEX_BITS{1'b0}};
         vtag_r       <= {TAG_BITS{1'b0}};
         vdata_r      <= {LINE_W{1'b0}};
         mem_req_r    <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= {ADDR_WIDTH{1'b0}};
         mem_wdata_r  <= {DATA_WIDTH{1'b0}};
         fill_valid_r <= 1'b0;
         fill_tag_r   <= {TAG_BITS{1'b0}};
         fill_index_r <= {INDEX_BITS{1'b0}};
         fill_data_r  <= {LINE_W{1'b0}};
         busy_r       <= 1'b0;
         miss_ready_r <= 1'b1;
      end else begin
         state_r      <= state_s;
         beat_r       <= beat_s;
         tag_r        <= tag_s;
         index_r      <= index_s;
         vtag_r       <= vtag_s;
         vdata_r      <= vdata_s;
         mem_req_r    <= mem_req_s;
         mem_we_r     <= mem_we_s;
         mem_addr_r   <= mem_addr_s;
         mem_wdata_r  <= mem_wdata_s;
         fill_valid_r <= fill_valid_s;
         fill_tag_r   <= fill_tag_s;
         fill_index_r <= fill_index_s;
         fill_data_r  <= fill_data_s;
         busy_r       <= busy_s;
         miss_ready_r <= miss_ready_s;
      end
   end

   assign o_miss_ready = miss_ready_r;
   assign o_mem_req    = mem_req_r;
   assign o_mem_we     = mem_we_r;
   assign o_mem_addr   = mem_addr_r;
   assign o_mem_wdata  = mem_wdata_r;
   assign o_fill_valid = fill_valid_r;
   assign o_fill_tag   = fill_tag_r;
   assign o_fill_index = fill_index_r;
   assign o_fill_data  = fill_data_r;
   assign o_busy       = busy_r;

endmodule
